// File: rtl/ring_meas_pkg.sv
// ring_meas_pkg: shared state encoding, default constants and enabled-ring search for the ring measurement scheduler
package ring_meas_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, GATE, REPORT} state_t;
  localparam int DEF_N_RING = 4;
  localparam int DEF_GATE_CYCLES = 100;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_CNT_W = 16;
  localparam int MAX_RING = 64;
  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } next_t;
  // lowest set bit of mask strictly above index from; from = -1 gives the lowest set bit
  function automatic next_t next_en(input logic [MAX_RING-1:0] mask, input int from);
    next_t r;
    r = '0;
    for (int i = MAX_RING - 1; i >= 0; i--)
      if (i > from && mask[6'(i)]) begin
        r.found = 1'b1;
        r.idx = 6'(i);
      end
    return r;
  endfunction
endpackage

// File: rtl/ring_edge_counter.sv
// ring_edge_counter: synchronises one ring input and counts its rising edges in a gate window; saturates when RING_CNT_SAT_EN is defined, wraps otherwise
module ring_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ring,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);
  logic s1, s2, prev;
  // two-flop synchroniser plus edge register; always tracking so a mux switch is absorbed during settle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, prev} <= 3'b000;
    else {s1, s2, prev} <= {ring, s1, s2};
  // count rising edges while enabled; ovf flags any increment attempted at all-ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf <= 1'b0;
    end else if (en && s2 && !prev) begin
      ovf <= ovf | (&count);
`ifdef RING_CNT_SAT_EN
      count <= (&count) ? count : count + 1'b1;
`else
      count <= count + 1'b1;
`endif
    end
endmodule

// File: rtl/ring_meas_scheduler.sv
// ring_meas_scheduler: round-robin settle/gate/report sequencer sharing one edge counter across ring inputs (RING_CNT_SAT_EN selects saturating count)
module ring_meas_scheduler
  import ring_meas_pkg::*;
#(
  parameter int N_RING = DEF_N_RING,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      continuous,
  input  logic [N_RING-1:0]         ring_en_mask,
  input  logic [N_RING-1:0]         ring_in,
  output logic [$clog2(N_RING)-1:0] ring_sel,
  output logic                      busy,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [CNT_W-1:0]          result_data,
  output logic [$clog2(N_RING)-1:0] result_id,
  output logic                      result_ovf,
  output logic                      sweep_done
);
  localparam int SW = $clog2(N_RING);
  localparam int TW = $clog2((GATE_CYCLES > SETTLE_CYCLES ? GATE_CYCLES : SETTLE_CYCLES) + 1);
  state_t state, state_d;
  logic [TW-1:0] tmr, tmr_d;
  logic [SW-1:0] sel_d;
  logic [N_RING-1:0] mask, mask_d;
  logic cont, cont_d, done_d;
  next_t fst, nxt, low;
  assign busy = state != IDLE;
  assign result_valid = state == REPORT;
  assign result_id = ring_sel;
  ring_edge_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ring  (ring_in[ring_sel]),
    .clr   (state == SETTLE),
    .en    (state == GATE),
    .count (result_data),
    .ovf   (result_ovf)
  );
  // scheduler state, phase timer, selected ring and captured sweep setup
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tmr <= '0;
      ring_sel <= '0;
      mask <= '0;
      cont <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state <= state_d;
      tmr <= tmr_d;
      ring_sel <= sel_d;
      mask <= mask_d;
      cont <= cont_d;
      sweep_done <= done_d;
    end
  // next-state: abort wins; settle and gate are timed; report waits for the handshake
  always_comb begin
    fst = next_en(MAX_RING'(ring_en_mask), -1);
    nxt = next_en(MAX_RING'(mask), int'(ring_sel));
    low = next_en(MAX_RING'(mask), -1);
    state_d = state;
    tmr_d = tmr;
    sel_d = ring_sel;
    mask_d = mask;
    cont_d = cont;
    done_d = 1'b0;
    if (abort) state_d = IDLE;
    else
      case (state)
        IDLE:
          if (start && fst.found) begin
            mask_d = ring_en_mask;
            cont_d = continuous;
            sel_d = SW'(fst.idx);
            tmr_d = TW'(SETTLE_CYCLES - 1);
            state_d = SETTLE;
          end
        SETTLE: begin
          tmr_d = tmr - 1'b1;
          if (tmr == '0) begin
            tmr_d = TW'(GATE_CYCLES - 1);
            state_d = GATE;
          end
        end
        GATE: begin
          tmr_d = tmr - 1'b1;
          if (tmr == '0) state_d = REPORT;
        end
        REPORT:
          if (result_ready) begin
            tmr_d = TW'(SETTLE_CYCLES - 1);
            state_d = nxt.found || (cont && low.found) ? SETTLE : IDLE;
            sel_d = nxt.found ? SW'(nxt.idx) : cont ? SW'(low.idx) : ring_sel;
            done_d = !nxt.found && !cont;
          end
        default: state_d = IDLE;
      endcase
  end
endmodule

// File: tb/tb_ring_meas_scheduler.sv
// tb_ring_meas_scheduler: table, random and hand-written sequences against an edges-per-window reference model
module tb_ring_meas_scheduler;
  localparam int G = 100, S = 4, LAT = S + G;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, continuous = 1'b0, result_ready = 1'b0;
  logic [3:0] ring_en_mask = 4'b0, ring_in;
  logic [1:0] ring_sel, result_id;
  logic busy, result_valid, result_ovf, sweep_done;
  logic [15:0] result_data;
  logic o_start = 1'b0;
  logic [3:0] o_ring, o_data;
  logic [1:0] o_sel, o_id;
  logic o_busy, o_valid, o_ovf, o_done;
  int per[4] = '{default: 0};
  int exp_d[4] = '{default: 0};
  int divs[9] = '{0, 2, 4, 5, 10, 20, 25, 50, 100};
  int cyc = 0, pass = 0, total = 0, done_seen = 0;
  typedef struct {
    logic [3:0] mask;
    int p[4];
    int stall;
    bit poke;
    int ex[4];
  } vec_t;
  vec_t tbl[5];

  ring_meas_scheduler #(.N_RING(4), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .continuous(continuous),
    .ring_en_mask(ring_en_mask), .ring_in(ring_in), .ring_sel(ring_sel), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
    .result_id(result_id), .result_ovf(result_ovf), .sweep_done(sweep_done));

  ring_meas_scheduler #(.N_RING(4), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(o_start), .abort(1'b0), .continuous(1'b0),
    .ring_en_mask(4'b0001), .ring_in(o_ring), .ring_sel(o_sel), .busy(o_busy),
    .result_valid(o_valid), .result_ready(1'b1), .result_data(o_data),
    .result_id(o_id), .result_ovf(o_ovf), .sweep_done(o_done));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sweep_done) done_seen <= done_seen + 1;
  end

  // ring waveforms: period p clk cycles, high for the first p/2; period 0 means stuck low
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) ring_in[i] <= per[i] == 0 ? 1'b0 : (cyc % per[i]) < per[i] / 2;
    o_ring <= {3'b000, 1'((cyc % 2) == 0)};
  end

  // reference: a periodic ring yields exactly window/period rising edges when period divides the window
  function automatic int model_count(input int p);
    return p == 0 ? 0 : G / p;
  endfunction

  task automatic chk(input string nm, input longint act, input longint want);
    total++;
    if (act == want) pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input logic [3:0] m, input int stall, input bit poke);
    int n;
    bit first;
    first = 1'b1;
    ring_en_mask = m;
    continuous = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ring_en_mask = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (!m[i]) continue;
      n = 0;
      while (!result_valid && n < 400) begin
        start = poke && first && n == 50;
        if (start) begin
          continuous = 1'b1;
          ring_en_mask = 4'hf;
        end
        tick();
        n++;
      end
      start = 1'b0;
      continuous = 1'b0;
      chk("latency", n, LAT);
      repeat (stall) begin
        chk("stall_valid", result_valid, 1);
        chk("stall_data", result_data, exp_d[i]);
        tick();
      end
      chk("id", result_id, i);
      chk("data", result_data, exp_d[i]);
      chk("ovf", result_ovf, 0);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      first = 1'b0;
      if ((m >> (i + 1)) != 0) chk("no_done_mid", sweep_done, 0);
    end
    chk("sweep_done", sweep_done, 1);
    chk("busy_end", busy, 0);
    tick();
    chk("done_pulse", sweep_done, 0);
  endtask

  initial begin
    int n, seen, d0;
    logic [3:0] m;
    tbl[0] = '{4'b0001, '{10, 0, 0, 0}, 0, 1'b0, '{10, 0, 0, 0}};
    tbl[1] = '{4'b1010, '{0, 4, 0, 20}, 7, 1'b0, '{0, 25, 0, 5}};
    tbl[2] = '{4'b1111, '{2, 5, 25, 100}, 2, 1'b0, '{50, 20, 4, 1}};
    tbl[3] = '{4'b0110, '{0, 0, 50, 0}, 1, 1'b0, '{0, 0, 2, 0}};
    tbl[4] = '{4'b0001, '{10, 0, 0, 0}, 0, 1'b1, '{10, 0, 0, 0}};
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_data", result_data, 0);
    chk("rst_sel", ring_sel, 0);
    chk("rst_id", result_id, 0);
    chk("rst_ovf", result_ovf, 0);
    chk("rst_done", sweep_done, 0);
    rst_n = 1'b1;
    tick();

    o_start = 1'b1;
    tick();
    o_start = 1'b0;
    n = 0;
    while (!o_valid && n < 400) begin
      tick();
      n++;
    end
    chk("ovf_latency", n, LAT);
`ifdef RING_CNT_SAT_EN
    chk("ovf_data", o_data, 15);
`else
    chk("ovf_data", o_data, 2);
`endif
    chk("ovf_flag", o_ovf, 1);

    ring_en_mask = 4'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mask0_busy", busy, 0);
    tick();
    chk("mask0_busy2", busy, 0);

    for (int t = 0; t < 5; t++) begin
      per = tbl[t].p;
      exp_d = tbl[t].ex;
      run_sweep(tbl[t].mask, tbl[t].stall, tbl[t].poke);
    end

    for (int r = 0; r < 6; r++) begin
      do m = 4'($urandom); while (m == 4'b0);
      for (int i = 0; i < 4; i++) begin
        per[i] = divs[$urandom_range(0, 8)];
        exp_d[i] = model_count(per[i]);
      end
      run_sweep(m, $urandom_range(0, 3), 1'b0);
    end

    per = '{10, 0, 20, 0};
    d0 = done_seen;
    ring_en_mask = 4'b0101;
    continuous = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    continuous = 1'b0;
    result_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!result_valid && n < 400) begin
        tick();
        n++;
      end
      chk("cont_latency", n, LAT);
      chk("cont_id", result_id, (k % 2) * 2);
      chk("cont_data", result_data, model_count(per[(k % 2) * 2]));
      tick();
    end
    repeat (50) tick();
    chk("pre_abort_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", result_valid, 0);
    seen = 0;
    repeat (200) begin
      tick();
      if (result_valid || busy) seen++;
    end
    chk("abort_quiet", seen, 0);
    chk("cont_no_done", done_seen - d0, 0);
    result_ready = 1'b0;

    per = '{10, 0, 10, 0};
    ring_en_mask = 4'b0100;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) tick();
    chk("pre_rst_sel", ring_sel, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_data", result_data, 0);
    chk("arst_sel", ring_sel, 0);
    chk("arst_id", result_id, 0);
    chk("arst_ovf", result_ovf, 0);
    chk("arst_done", sweep_done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_d = '{10, 0, 10, 0};
    run_sweep(4'b0001, 0, 1'b0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
